mult_div_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS datapath, parametrised in operand width. It executes the R-type HI/LO group: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. It decodes `funct` itself, like the ALU control path, but runs multi-cycle with a start/busy/done handshake and owns the architectural HI and LO registers. It sits beside the single-cycle ALU; the main controller stalls on `stall`.

---
 rtl/mult_div_unit_pkg.sv | 21 ++
 rtl/mult_div_unit_iter_core.sv | 61 ++++++
 rtl/mult_div_unit.sv | 150 +++++++++++++++
 tb/tb_mult_div_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: MIPS HI/LO-group funct codes and the state encoding
// shared by the multiply/divide unit.
package mult_div_unit_pkg;

    // R-type funct field values for the HI/LO instruction group
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/mult_div_unit_iter_core.sv
// muldiv_iter_core: one-bit-per-cycle datapath. Multiply is shift-add into a
// 2*WIDTH accumulator; divide is restoring shift-subtract with the remainder
// in the upper half and the quotient shifting into the lower half.
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_is_div,
    input  logic [WIDTH-1:0]   i_opa,
    input  logic [WIDTH-1:0]   i_opb,
    output logic [2*WIDTH-1:0] o_acc,
    output logic               o_last
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_next;

    // Next accumulator value for one multiply or divide iteration
    always_comb begin
        w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
        w_shift = r_acc[2*WIDTH-1:WIDTH-1];
        w_diff  = w_shift - {1'b0, r_opb};
        w_qbit  = ~w_diff[WIDTH];
        if (i_is_div)
            w_next = {(w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]),
                      r_acc[WIDTH-2:0], w_qbit};
        else
            w_next = {w_sum, r_acc[WIDTH-1:1]};
    end

    // Load operands and iteration count, then step once per RUN cycle
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_acc <= '0;
            r_opb <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_acc <= {{WIDTH{1'b0}}, i_opa};
            r_opb <= i_opb;
            r_cnt <= CW'(WIDTH);
        end else if (i_step) begin
            r_acc <= w_next;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_acc  = r_acc;
    assign o_last = (r_cnt == CW'(1));

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU plus MFHI/MFLO/MTHI/MTLO,
// owning the architectural HI/LO registers. Latency WIDTH+1 edges.
// Define MULTDIV_SIGNED_EN to make MULT/DIV signed; otherwise they behave as
// MULTU/DIVU and the sign-correction logic is absent.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);
    md_state_t r_state, w_state_nxt;

    logic               w_is_mul, w_is_div, w_sgn, w_accept, w_load, w_last;
    logic               w_sa, w_sb;
    logic [WIDTH-1:0]   w_amag, w_bmag;
    logic [2*WIDTH-1:0] w_acc, w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem;

    logic               r_is_div, r_bzero, r_done;
    logic [WIDTH-1:0]   r_a, r_hi, r_lo;

    assign w_is_mul = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    assign w_is_div = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
`ifdef MULTDIV_SIGNED_EN
    assign w_sgn    = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
`else
    assign w_sgn    = 1'b0;
`endif
    assign busy     = (r_state != MD_IDLE);
    assign w_accept = start & ~busy;
    assign w_load   = w_accept & (w_is_mul | w_is_div);
    assign stall    = start & busy;

    assign w_sa   = w_sgn & a[WIDTH-1];
    assign w_sb   = w_sgn & b[WIDTH-1];
    assign w_amag = w_sa ? -a : a;
    assign w_bmag = w_sb ? -b : b;

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rstb     (rstb),
        .i_load   (w_load),
        .i_step   (r_state == MD_RUN),
        .i_is_div (r_is_div),
        .i_opa    (w_amag),
        .i_opb    (w_bmag),
        .o_acc    (w_acc),
        .o_last   (w_last)
    );

`ifdef MULTDIV_SIGNED_EN
    logic r_neg_q, r_neg_r;

    // Latch result sign flags when an operation is accepted
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_load) begin
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
        end
    end

    // Sign correction: product/quotient negate on differing signs,
    // remainder follows the dividend
    always_comb begin
        w_prod = r_neg_q ? -w_acc : w_acc;
        w_quo  = r_neg_q ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
        w_rem  = r_neg_r ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];
    end
`else
    // Unsigned build: results come straight from the accumulator
    always_comb begin
        w_prod = w_acc;
        w_quo  = w_acc[WIDTH-1:0];
        w_rem  = w_acc[2*WIDTH-1:WIDTH];
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) r_state <= MD_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next state: RUN for WIDTH iterations, then one FIX cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: if (w_load) w_state_nxt = MD_RUN;
            MD_RUN:  if (w_last) w_state_nxt = MD_FIX;
            MD_FIX:  w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    // HI/LO ownership: result write at FIX, direct moves when idle
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_is_div <= 1'b0;
            r_bzero  <= 1'b0;
            r_a      <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_is_div <= w_is_div;
                r_bzero  <= (b == '0);
                r_a      <= a;
            end
            if (r_state == MD_FIX) begin
                r_done <= 1'b1;
                if (!r_is_div) begin
                    {r_hi, r_lo} <= w_prod;
                end else if (r_bzero) begin
                    r_lo <= '1;
                    r_hi <= r_a;
                end else begin
                    r_lo <= w_quo;
                    r_hi <= w_rem;
                end
            end else if (w_accept && funct == FUNCT_MTHI) begin
                r_hi <= a;
            end else if (w_accept && funct == FUNCT_MTLO) begin
                r_lo <= a;
            end
        end
    end

    assign hi      = r_hi;
    assign lo      = r_lo;
    assign done    = r_done;
    assign rd_data = (funct == FUNCT_MFHI) ? r_hi : r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed checks of mult_div_unit at WIDTH=32. Expected
// values for MULT/DIV follow MULTDIV_SIGNED_EN when defined, else unsigned.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'h00;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, stall;
    logic [31:0] hi, lo, rd_data;

    int checks = 0;
    int failures = 0;
    int n_edges, n_busy;
    logic saw_done;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rstb(rstb), .start(start), .funct(funct), .a(a), .b(b),
        .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one op, then count edges after the start edge until done
    task automatic run_op(input logic [5:0] f, input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1; funct = f; a = va; b = vb;
        tick();
        start = 1'b0; funct = 6'h00;
        n_edges = 0; n_busy = 0;
        while (!done && n_edges < 100) begin
            if (busy) n_busy++;
            tick();
            n_edges++;
        end
    endtask

    initial begin
        #1;
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        @(negedge clk);
        rstb = 1'b1;
        tick();

        // 1: MULTU max * 2
        run_op(6'h19, 32'hFFFFFFFF, 32'd2);
        chk("multu_latency", n_edges, 32'd33);
        chk("multu_busy_cycles", n_busy, 32'd33);
        chk("multu_done", {31'b0, done}, 32'h1);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);
        tick();
        chk("done_one_cycle", {31'b0, done}, 32'h0);

        // 2: MULT -3 * 5
        run_op(6'h18, 32'hFFFFFFFD, 32'd5);
`ifdef MULTDIV_SIGNED_EN
        chk("mult_hi", hi, 32'hFFFFFFFF);
`else
        chk("mult_hi", hi, 32'h00000004);
`endif
        chk("mult_lo", lo, 32'hFFFFFFF1);

        // 3: DIV -7 / 2, then MIN_INT / -1
        run_op(6'h1A, 32'hFFFFFFF9, 32'd2);
`ifdef MULTDIV_SIGNED_EN
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
`else
        chk("div_lo", lo, 32'h7FFFFFFC);
        chk("div_hi", hi, 32'h00000001);
`endif
        run_op(6'h1A, 32'h80000000, 32'hFFFFFFFF);
        chk("div_min_latency", n_edges, 32'd33);
`ifdef MULTDIV_SIGNED_EN
        chk("div_min_lo", lo, 32'h80000000);
        chk("div_min_hi", hi, 32'h00000000);
`else
        chk("div_min_lo", lo, 32'h00000000);
        chk("div_min_hi", hi, 32'h80000000);
`endif

        // 4: DIVU by zero, then MFHI/MFLO read-back
        run_op(6'h1B, 32'd10, 32'd0);
        chk("div0_latency", n_edges, 32'd33);
        chk("div0_lo", lo, 32'hFFFFFFFF);
        chk("div0_hi", hi, 32'h0000000A);
        funct = 6'h10; #1;
        chk("mfhi_rd", rd_data, 32'h0000000A);
        funct = 6'h12; #1;
        chk("mflo_rd", rd_data, 32'hFFFFFFFF);
        funct = 6'h00;
        tick();

        // 5: MTLO while busy is ignored; MTLO/MTHI when idle take effect
        start = 1'b1; funct = 6'h19; a = 32'd3; b = 32'd4;
        tick();
        funct = 6'h13; a = 32'h1234; #1;
        chk("busy_stall", {31'b0, stall}, 32'h1);
        tick(); tick();
        chk("busy_mtlo_lo", lo, 32'hFFFFFFFF);
        start = 1'b0; funct = 6'h00;
        n_edges = 2;
        while (!done && n_edges < 100) begin
            tick();
            n_edges++;
        end
        chk("busy_mul_latency", n_edges, 32'd33);
        chk("busy_mul_lo", lo, 32'h0000000C);
        chk("busy_mul_hi", hi, 32'h00000000);
        tick();
        start = 1'b1; funct = 6'h13; a = 32'h1234; #1;
        chk("idle_stall", {31'b0, stall}, 32'h0);
        tick();
        start = 1'b0; funct = 6'h00;
        chk("mtlo_lo", lo, 32'h00001234);
        chk("mtlo_done", {31'b0, done}, 32'h0);
        chk("mtlo_busy", {31'b0, busy}, 32'h0);
        start = 1'b1; funct = 6'h11; a = 32'h55;
        tick();
        start = 1'b0; funct = 6'h00;
        chk("mthi_hi", hi, 32'h00000055);
        chk("mthi_lo_kept", lo, 32'h00001234);

        // 6: reset in the middle of a multiply
        start = 1'b1; funct = 6'h19; a = 32'd7; b = 32'd9;
        tick();
        start = 1'b0; funct = 6'h00;
        repeat (10) tick();
        rstb = 1'b0; #1;
        chk("rst_mid_hi", hi, 32'h0);
        chk("rst_mid_lo", lo, 32'h0);
        chk("rst_mid_busy", {31'b0, busy}, 32'h0);
        saw_done = 1'b0;
        repeat (3) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        rstb = 1'b1;
        repeat (30) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        chk("rst_no_done", {31'b0, saw_done}, 32'h0);
        run_op(6'h19, 32'd6, 32'd7);
        chk("post_rst_latency", n_edges, 32'd33);
        chk("post_rst_lo", lo, 32'd42);
        chk("post_rst_hi", hi, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
